// File: rtl/period_meter.sv
// period_meter: measures the period and high time of an asynchronous sig_in in clkin cycles.
// Define PERIOD_METER_AVG_EN to report period as the truncated mean of the last four periods.
module period_meter #(
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2    // must be at least 2
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchroniser, delay flop and registered edge detect.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_last;

  // Measurement state and published results.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic             fall_seen_q, fall_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] meas_high;

`ifdef PERIOD_METER_AVG_EN
  localparam int ACC_W = CNT_W + 2;

  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W-1:0] hist_d [4];
  logic [2:0]       hist_cnt_q, hist_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] avg_period;
  logic             hist_full;
  logic             hist_push;
  logic             hist_flush;
`endif

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    dly_d  = sync_last;
    rise_d = sync_last & ~dly_q;
    fall_d = ~sync_last & dly_q;
  end

`ifdef PERIOD_METER_AVG_EN
  // Running sum of the window including the period that is closing right now.
  assign hist_full  = (hist_cnt_q == 3'd4);
  assign acc_sum    = acc_q + ACC_W'(cnt_q) - (hist_full ? ACC_W'(hist_q[3]) : '0);
  assign avg_period = acc_sum[ACC_W-1:2];
`endif

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cnt_d    = hi_cnt_q;
    fall_seen_d = fall_seen_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    // A period with no fall was high throughout.
    meas_high   = fall_seen_q ? hi_cnt_q : cnt_q;
`ifdef PERIOD_METER_AVG_EN
    hist_push   = 1'b0;
    hist_flush  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_q) begin
          state_d     = MEASURE;
          cnt_d       = CNT_ONE;
          fall_seen_d = 1'b0;
`ifdef PERIOD_METER_AVG_EN
          hist_flush  = 1'b1;
`endif
        end
      end

      MEASURE: begin
        if (rise_q) begin
          cnt_d       = CNT_ONE;
          fall_seen_d = 1'b0;
`ifdef PERIOD_METER_AVG_EN
          hist_push   = 1'b1;
          if (hist_cnt_q >= 3'd3) begin
            period_d    = avg_period;
            high_time_d = meas_high;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
          end
`else
          period_d    = cnt_q;
          high_time_d = meas_high;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
`endif
        end else if (cnt_q == CNT_MAX) begin
          // Saturated without a rise: abandon the period, keep the last published result.
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
`ifdef PERIOD_METER_AVG_EN
          hist_flush = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (fall_q) begin
            hi_cnt_d    = cnt_q;
            fall_seen_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef PERIOD_METER_AVG_EN
  always_comb begin
    hist_d     = hist_q;
    hist_cnt_d = hist_cnt_q;
    acc_d      = acc_q;
    if (hist_flush) begin
      hist_cnt_d = '0;
      acc_d      = '0;
    end else if (hist_push) begin
      hist_d[0] = cnt_q;
      for (int i = 1; i < 4; i++) hist_d[i] = hist_q[i-1];
      acc_d = acc_sum;
      if (!hist_full) hist_cnt_d = hist_cnt_q + 3'd1;
    end
  end

  // NOTE: history entries carry no reset; hist_cnt_q gates every use of them.
  always_ff @(posedge clkin) begin
    hist_q <= hist_d;
  end
`endif

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      dly_q       <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cnt_q    <= '0;
      fall_seen_q <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      hist_cnt_q  <= '0;
      acc_q       <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      dly_q       <= dly_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      fall_seen_q <= fall_seen_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
`ifdef PERIOD_METER_AVG_EN
      hist_cnt_q  <= hist_cnt_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed square waves on sig_in; a queue-based scoreboard
// checks every valid pulse (values and arrival cycle) against a period-level reference model.
module tb_period_meter;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_CNT     = (1 << CNT_W) - 1;
  localparam int LAT         = SYNC_STAGES + 2;  // drive cycle -> cycle valid is seen

  logic             clkin = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;

  period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: tracks whole periods, not counters.
  typedef struct {
    int period;
    int high;
    int cyc;
  } exp_t;

  exp_t sb[$];
  bit   pending;
  int   prev_n, prev_h;
  int   last_period, last_high;
`ifdef PERIOD_METER_AVG_EN
  int   hist[$];
`endif

  task automatic model_flush();
`ifdef PERIOD_METER_AVG_EN
    hist.delete();
`endif
  endtask

  task automatic model_reset();
    pending     = 1'b0;
    sb.delete();
    model_flush();
    last_period = 0;
    last_high   = 0;
  endtask

  // Called at the cycle a rise is driven; closes the previous period if one was open.
  task automatic model_rise(input int n, input int h);
    exp_t e;
    if (pending) begin
      if (prev_n <= MAX_CNT) begin
`ifdef PERIOD_METER_AVG_EN
        hist.push_back(prev_n);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
          e.period = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
          e.high   = prev_h;
          e.cyc    = cyc + LAT;
          sb.push_back(e);
          last_period = e.period;
          last_high   = e.high;
        end
`else
        e.period = prev_n;
        e.high   = prev_h;
        e.cyc    = cyc + LAT;
        sb.push_back(e);
        last_period = e.period;
        last_high   = e.high;
`endif
      end else begin
        model_flush();  // the open period timed out
      end
    end
    pending = 1'b1;
    prev_n  = n;
    prev_h  = h;
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clkin);
      #2;
    end
  endtask

  task automatic drive_period(input int n, input int h);
    model_rise(n, h);
    sig_in = 1'b1;
    tick(h);
    sig_in = 1'b0;
    tick(n - h);
  endtask

  // Monitor: pops and compares on every valid pulse.
  always @(negedge clkin) begin
    exp_t e;
    if (!reset && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", int'(valid), 0);
      end else begin
        e = sb.pop_front();
        check("period", int'(period), e.period);
        check("high_time", int'(high_time), e.high);
        check("valid_cycle", cyc, e.cyc);
        check("timeout_clear_on_valid", int'(timeout), 0);
      end
    end
  end

  int t0;
  int n, h;
  int avg_seq [5] = '{100, 104, 96, 100, 108};

  initial begin
    reset  = 1'b1;
    sig_in = 1'b1;
    model_reset();
    #1;
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(timeout), 0);
    tick(3);

    // sig_in already high at release: one measurement start, then saturation.
    reset = 1'b0;
    t0    = cyc;
    model_rise(1 << 20, 1 << 20);
    for (int i = 0; i < MAX_CNT + LAT + 20; i++) begin
      @(negedge clkin);
      if (timeout) break;
    end
    check("const_high_timeout", int'(timeout), 1);
    check("const_high_timeout_cycle", cyc, t0 + LAT + MAX_CNT);
    check("const_high_period", int'(period), 0);
    check("const_high_high_time", int'(high_time), 0);
    tick(1);
    sig_in = 1'b0;
    tick(10);

    // Clean square wave 100/30.
    repeat (4) drive_period(100, 30);

    // Random periods, including one-cycle high and low phases.
    repeat (20) begin
      n = int'($urandom_range(200, 2));
      h = int'($urandom_range(n - 1, 1));
      drive_period(n, h);
    end

    // Saturation boundary: 255 is measured, 256 times out just before the next rise.
    drive_period(255, 40);
    drive_period(256, 40);
    drive_period(100, 30);
    check("timeout_set", int'(timeout), 1);
    check("timeout_period_held", int'(period), last_period);
    check("timeout_high_held", int'(high_time), last_high);
    drive_period(100, 30);
    check("timeout_cleared", int'(timeout), 0);
    drive_period(100, 30);

    // Reset 50 cycles into a 100-cycle period.
    model_rise(100, 30);
    sig_in = 1'b1;
    tick(30);
    sig_in = 1'b0;
    tick(20);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_period", int'(period), 0);
    check("midrst_high_time", int'(high_time), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_timeout", int'(timeout), 0);
    model_reset();
    tick(2);
    reset = 1'b0;
    tick(48);

    // Period sequence for the averaging window, then a closing period.
    foreach (avg_seq[i]) drive_period(avg_seq[i], 40);
    drive_period(50, 20);

    // Leave sig_in low until the open period saturates.
    tick(MAX_CNT + 20);
    check("final_timeout", int'(timeout), 1);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
